// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : Local parallel-side bus of the SPI slave. Carries the
//                transmit-word write port and the receive-word/status outputs
//                between the SPI slave and the local logic that owns it.
//  Signals     : DATA_IN  - transmit word written into the holding buffer
//                TX_WR    - write strobe for DATA_IN
//                TX_FULL  - holding buffer contains an unsent word
//                DATA_OUT - last complete received word
//                RX_VALID - one-cycle strobe when DATA_OUT updates
//                UNDERRUN - one-cycle strobe when a word load found no data
//                BUSY     - slave select is active (synchronized)
//  Modports    : slave  - the SPI slave block
//                master - the local logic / testbench driving the block
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  TX_WR;
    logic                  TX_FULL;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  RX_VALID;
    logic                  UNDERRUN;
    logic                  BUSY;

    modport slave (
        input  DATA_IN, TX_WR,
        output TX_FULL, DATA_OUT, RX_VALID, UNDERRUN, BUSY
    );

    modport master (
        output DATA_IN, TX_WR,
        input  TX_FULL, DATA_OUT, RX_VALID, UNDERRUN, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : 4-wire SPI slave. SCLK, SS and SDI are oversampled in the CLK
//                domain; words of DATA_WIDTH bits are shifted MSB-first in both
//                directions in any CPOL/CPHA mode. Received words appear on
//                DATA_OUT with a one-cycle RX_VALID strobe; transmit words come
//                from a one-entry holding buffer written through TX_WR.
//  Ports       : CLK    - system clock
//                RESET  - asynchronous reset, active-low
//                SCLK   - SPI clock from the master (asynchronous)
//                SS     - slave select, active-low (asynchronous)
//                SDI    - master-out serial data (asynchronous)
//                SDO    - slave-out serial data, high-Z while SS is inactive
//                bus    - parallel side (spi_slave_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter int DATA_WIDTH = 16
) (
    input  wire        CLK,
    input  wire        RESET,
    input  wire        SCLK,
    input  wire        SS,
    input  wire        SDI,
    output wire        SDO,
    spi_slave_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                state_q;
    logic [2:0]            sclk_q;      // [1:0] synchronizer, [2] edge history
    logic [2:0]            ss_q;
    logic [1:0]            sdi_q;
    logic [1:0]            vld_q;       // marks when ss_q[1] holds a real sample
    logic                  armed_q;     // SS has been seen inactive since reset
    logic                  first_q;
    logic                  done_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  tx_full_q;
    logic                  rx_valid_q;
    logic                  underrun_q;
    logic                  busy_q;

    logic w_lead;
    logic w_trail;
    logic w_ss_fall;
    logic w_ss_rise;
    logic w_sample;
    logic w_shift_act;
    logic w_load;

    assign w_lead    = (sclk_q[1] != CPOL) && (sclk_q[2] == CPOL);
    assign w_trail   = (sclk_q[1] == CPOL) && (sclk_q[2] != CPOL);

    // A falling SS only starts a frame once SS has been observed high after
    // reset, so a frame already in flight when reset releases is ignored.
    assign w_ss_fall = (state_q == ST_IDLE) && armed_q && ss_q[2] && !ss_q[1];
    assign w_ss_rise = ss_q[1] && !ss_q[2];

    assign w_sample  = CPHA ? w_trail : w_lead;

    // Shift edges coincident with SS deassertion are dropped so an ending
    // frame never consumes another buffered word. With CPHA=1 the first
    // leading edge only clears first_q: the MSB is already on SDO.
    assign w_shift_act = (state_q == ST_ACTIVE) && (CPHA ? w_lead : w_trail)
                         && !w_ss_rise && !(CPHA && first_q);

    assign w_load = w_ss_fall || (w_shift_act && (cnt_q == '0) && !first_q);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            sclk_q     <= {3{CPOL}};
            ss_q       <= 3'b111;
            sdi_q      <= 2'b00;
            vld_q      <= 2'b00;
            armed_q    <= 1'b0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            buf_q      <= '0;
            data_out_q <= '0;
            tx_full_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], SCLK};
            ss_q   <= {ss_q[1:0], SS};
            sdi_q  <= {sdi_q[0], SDI};
            vld_q  <= {vld_q[0], 1'b1};
            if (vld_q[1] && ss_q[1]) begin
                armed_q <= 1'b1;
            end

            // Completed word is published one cycle after its last sample.
            done_q     <= 1'b0;
            rx_valid_q <= done_q;
            underrun_q <= 1'b0;
            if (done_q) begin
                data_out_q <= rx_q;
            end

            // Holding buffer and transmit shifter. On a load the shifter takes
            // the old buffer contents; a same-cycle write stays buffered, or
            // goes straight to the shifter when the buffer was empty.
            if (bus.TX_WR) begin
                buf_q <= bus.DATA_IN;
            end
            if (w_load) begin
                tx_full_q <= tx_full_q & bus.TX_WR;
                if (tx_full_q) begin
                    tx_q <= buf_q;
                end else if (bus.TX_WR) begin
                    tx_q <= bus.DATA_IN;
                end else begin
                    tx_q       <= '0;
                    underrun_q <= 1'b1;
                end
            end else begin
                if (bus.TX_WR) begin
                    tx_full_q <= 1'b1;
                end
                if (w_shift_act) begin
                    tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        state_q <= ST_ACTIVE;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (w_lead) begin
                        first_q <= 1'b0;
                    end
                    if (w_sample) begin
                        rx_q <= {rx_q[DATA_WIDTH-2:0], sdi_q[1]};
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            cnt_q  <= '0;
                            done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    // Placed after the sample so a final sample coincident
                    // with SS rising still completes its word.
                    if (w_ss_rise) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SDO          = ss_q[1] ? 1'bz : tx_q[DATA_WIDTH-1];
    assign bus.TX_FULL  = tx_full_q;
    assign bus.DATA_OUT = data_out_q;
    assign bus.RX_VALID = rx_valid_q;
    assign bus.UNDERRUN = underrun_q;
    assign bus.BUSY     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_slave
//  Description : Testbench for spi_slave. A mode-0 and a mode-3 instance share
//                one behavioural SPI master. Expected received words are
//                queued per instance and checked by monitors on RX_VALID;
//                UNDERRUN pulses are counted against expected counts.
//                SDO nets carry pull-ups so a released line reads as 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int W    = 16;
    localparam int HALF = 5;    // SCLK half period in CLK cycles (CLK/10)

    logic clk = 1'b0;
    logic rst0_n, rst3_n;
    logic m_sclk, m_ss, m_sdi;
    logic sel3;                 // 0: master talks to mode-0 DUT, 1: mode-3 DUT
    bit   cpol, cpha;

    wire  sclk0, ss0, sclk3, ss3;
    wire  sdo0, sdo3, sdo_m;

    assign sclk0 = sel3 ? 1'b0 : m_sclk;
    assign ss0   = sel3 ? 1'b1 : m_ss;
    assign sclk3 = sel3 ? m_sclk : 1'b1;
    assign ss3   = sel3 ? m_ss : 1'b1;
    assign sdo_m = sel3 ? sdo3 : sdo0;

    pullup pu0 (sdo0);
    pullup pu3 (sdo3);

    spi_slave_if #(.DATA_WIDTH(W)) bus0 ();
    spi_slave_if #(.DATA_WIDTH(W)) bus3 ();

    spi_slave #(.CPOL(1'b0), .CPHA(1'b0), .DATA_WIDTH(W)) u_dut0 (
        .CLK(clk), .RESET(rst0_n), .SCLK(sclk0), .SS(ss0), .SDI(m_sdi),
        .SDO(sdo0), .bus(bus0.slave)
    );

    spi_slave #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WIDTH(W)) u_dut3 (
        .CLK(clk), .RESET(rst3_n), .SCLK(sclk3), .SS(ss3), .SDI(m_sdi),
        .SDO(sdo3), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ur_cnt0  = 0, ur_cnt3 = 0;
    int exp_ur0  = 0, exp_ur3 = 0;
    int sdo_viol = 0;
    logic [W-1:0] exp_rx0[$];
    logic [W-1:0] exp_rx3[$];
    logic [63:0]  miso;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every RX_VALID must match the oldest expected word.
    always @(negedge clk) begin
        if (bus0.RX_VALID) begin
            check("rx0_word_expected", 32'(exp_rx0.size() > 0), 32'd1);
            if (exp_rx0.size() > 0) check("rx0_data", 32'(bus0.DATA_OUT), 32'(exp_rx0.pop_front()));
        end
        if (bus3.RX_VALID) begin
            check("rx3_word_expected", 32'(exp_rx3.size() > 0), 32'd1);
            if (exp_rx3.size() > 0) check("rx3_data", 32'(bus3.DATA_OUT), 32'(exp_rx3.pop_front()));
        end
        if (bus0.UNDERRUN) ur_cnt0++;
        if (bus3.UNDERRUN) ur_cnt3++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input bit to3, input logic [W-1:0] d);
        if (to3) begin bus3.DATA_IN = d; bus3.TX_WR = 1'b1; end
        else     begin bus0.DATA_IN = d; bus0.TX_WR = 1'b1; end
        wait_clk(1);
        bus0.TX_WR = 1'b0;
        bus3.TX_WR = 1'b0;
    endtask

    // Behavioural master: nbits MSB-first. start drives SS low first; stop
    // raises SS at the end (CPHA=0: after the last leading edge, before SCLK
    // returns to idle).
    task automatic xfer(input int nbits, input logic [63:0] mosi,
                        output logic [63:0] mi, input bit start, input bit stop);
        logic pre;
        bit   have_pre;
        pre      = 1'b0;
        have_pre = 1'b0;
        mi       = '0;
        if (start) begin
            m_ss = 1'b0;
            if (!cpha) m_sdi = mosi[nbits-1];
            wait_clk(HALF);
        end
        for (int i = nbits - 1; i >= 0; i--) begin
            m_sclk = ~cpol;
            if (!cpha) begin
                mi[i] = sdo_m;
            end else begin
                m_sdi = mosi[i];
                if (have_pre && (sdo_m !== pre)) sdo_viol++;
            end
            wait_clk(HALF);
            if (stop && (i == 0) && !cpha) begin
                m_ss = 1'b1;
                wait_clk(HALF);
                m_sclk = cpol;
                wait_clk(HALF);
            end else begin
                m_sclk = cpol;
                if (!cpha) begin
                    if (i > 0) m_sdi = mosi[i-1];
                end else begin
                    mi[i]    = sdo_m;
                    pre      = sdo_m;
                    have_pre = 1'b1;
                end
                wait_clk(HALF);
            end
        end
        if (stop && cpha) begin
            m_ss = 1'b1;
            wait_clk(HALF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0_n = 1'b0; rst3_n = 1'b0;
        m_sclk = 1'b0; m_ss = 1'b1; m_sdi = 1'b0;
        sel3 = 1'b0; cpol = 1'b0; cpha = 1'b0;
        bus0.TX_WR = 1'b0; bus0.DATA_IN = '0;
        bus3.TX_WR = 1'b0; bus3.DATA_IN = '0;
        wait_clk(3);
        rst0_n = 1'b1; rst3_n = 1'b1;
        wait_clk(4);

        // Reset state
        check("rst_data_out0", 32'(bus0.DATA_OUT), 32'h0);
        check("rst_tx_full0",  32'(bus0.TX_FULL),  32'h0);
        check("rst_busy0",     32'(bus0.BUSY),     32'h0);
        check("rst_rx_valid0", 32'(bus0.RX_VALID), 32'h0);
        check("rst_sdo0_hiz",  32'(sdo0),          32'h1);
        check("rst_data_out3", 32'(bus3.DATA_OUT), 32'h0);
        check("rst_sdo3_hiz",  32'(sdo3),          32'h1);

        // Mode 0 single word
        tx_write(1'b0, 16'h3C5A);
        check("m0_tx_full_set", 32'(bus0.TX_FULL), 32'h1);
        exp_rx0.push_back(16'hA55A);
        fork
            xfer(16, 64'hA55A, miso, 1'b1, 1'b1);
            begin
                wait_clk(5);
                check("m0_tx_full_clr", 32'(bus0.TX_FULL), 32'h0);
                check("m0_busy",        32'(bus0.BUSY),    32'h1);
            end
        join
        wait_clk(4);
        check("m0_miso",     miso[31:0], 32'h3C5A);
        check("m0_rx_done",  32'(exp_rx0.size()), 32'h0);
        check("m0_underrun", 32'(ur_cnt0), 32'(exp_ur0));
        check("m0_busy_end", 32'(bus0.BUSY), 32'h0);

        // Two-word burst with the second word written during word 1
        tx_write(1'b0, 16'h1111);
        exp_rx0.push_back(16'h0F0F);
        exp_rx0.push_back(16'hF00F);
        fork
            xfer(32, 64'h0F0F_F00F, miso, 1'b1, 1'b1);
            begin
                wait_clk(40);
                tx_write(1'b0, 16'h2222);
            end
        join
        wait_clk(4);
        check("burst_miso",     miso[31:0], 32'h1111_2222);
        check("burst_rx_done",  32'(exp_rx0.size()), 32'h0);
        check("burst_underrun", 32'(ur_cnt0), 32'(exp_ur0));

        // No word buffered: zeros go out and one UNDERRUN
        exp_ur0++;
        exp_rx0.push_back(16'h1234);
        xfer(16, 64'h1234, miso, 1'b1, 1'b1);
        wait_clk(4);
        check("ur_miso",     miso[31:0], 32'h0);
        check("ur_rx_done",  32'(exp_rx0.size()), 32'h0);
        check("ur_underrun", 32'(ur_cnt0), 32'(exp_ur0));

        // Abort after 7 bits (shifter holds zeros from the underrun load)
        exp_ur0++;
        xfer(7, 64'h55, miso, 1'b1, 1'b0);
        check("abort_sdo_driven", 32'(sdo0), 32'h0);
        check("abort_busy",       32'(bus0.BUSY), 32'h1);
        m_ss = 1'b1;
        wait_clk(3);
        check("abort_sdo_hiz",    32'(sdo0), 32'h1);
        check("abort_busy_clr",   32'(bus0.BUSY), 32'h0);
        check("abort_data_kept",  32'(bus0.DATA_OUT), 32'h1234);
        check("abort_underrun",   32'(ur_cnt0), 32'(exp_ur0));
        wait_clk(HALF);
        tx_write(1'b0, 16'hBEEF);
        exp_rx0.push_back(16'h7E81);
        xfer(16, 64'h7E81, miso, 1'b1, 1'b1);
        wait_clk(4);
        check("after_abort_miso",    miso[31:0], 32'hBEEF);
        check("after_abort_rx_done", 32'(exp_rx0.size()), 32'h0);

        // Mode 3 (CPOL=1, CPHA=1)
        m_sclk = 1'b1; sel3 = 1'b1; cpol = 1'b1; cpha = 1'b1;
        wait_clk(HALF);
        tx_write(1'b1, 16'h3C5A);
        check("m3_tx_full_set", 32'(bus3.TX_FULL), 32'h1);
        exp_rx3.push_back(16'hA55A);
        sdo_viol = 0;
        fork
            xfer(16, 64'hA55A, miso, 1'b1, 1'b1);
            begin
                wait_clk(5);
                check("m3_tx_full_clr", 32'(bus3.TX_FULL), 32'h0);
            end
        join
        wait_clk(4);
        check("m3_miso",         miso[31:0], 32'h3C5A);
        check("m3_rx_done",      32'(exp_rx3.size()), 32'h0);
        check("m3_data_out",     32'(bus3.DATA_OUT), 32'hA55A);
        check("m3_sdo_lead_only", 32'(sdo_viol), 32'h0);
        check("m3_underrun",     32'(ur_cnt3), 32'(exp_ur3));
        m_sclk = 1'b0; sel3 = 1'b0; cpol = 1'b0; cpha = 1'b0;
        wait_clk(HALF);

        // Reset mid-word on the mode-0 DUT
        tx_write(1'b0, 16'h1357);
        xfer(7, 64'h66, miso, 1'b1, 1'b0);
        tx_write(1'b0, 16'h2468);
        check("rstmid_tx_full_pre", 32'(bus0.TX_FULL), 32'h1);
        rst0_n = 1'b0;
        #1;
        check("rstmid_data_out", 32'(bus0.DATA_OUT), 32'h0);
        check("rstmid_tx_full",  32'(bus0.TX_FULL),  32'h0);
        check("rstmid_busy",     32'(bus0.BUSY),     32'h0);
        check("rstmid_rx_valid", 32'(bus0.RX_VALID), 32'h0);
        check("rstmid_underrun", 32'(bus0.UNDERRUN), 32'h0);
        check("rstmid_sdo_hiz",  32'(sdo0),          32'h1);
        wait_clk(2);
        rst0_n = 1'b1;
        xfer(9, 64'h1FF, miso, 1'b0, 1'b0);
        check("rstmid_ignored_busy", 32'(bus0.BUSY), 32'h0);
        m_ss = 1'b1;
        wait_clk(HALF);
        check("rstmid_ignored_ur", 32'(ur_cnt0), 32'(exp_ur0));
        tx_write(1'b0, 16'hC0DE);
        exp_rx0.push_back(16'h5AA5);
        xfer(16, 64'h5AA5, miso, 1'b1, 1'b1);
        wait_clk(4);
        check("after_rst_miso",    miso[31:0], 32'hC0DE);
        check("after_rst_rx_done", 32'(exp_rx0.size()), 32'h0);
        check("after_rst_data",    32'(bus0.DATA_OUT), 32'h5AA5);
        check("final_underrun0",   32'(ur_cnt0), 32'(exp_ur0));
        check("final_underrun3",   32'(ur_cnt3), 32'(exp_ur3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
